l2_arbiter: RTL and testbench

- Shares the single unified L2 cache port between the L1 instruction cache (requester I) and the L1 data cache (requester D).
- Sits between both L1 cache controllers and the L2 cache, and owns the L2 request interface.
- Grants one requester at a time and holds that grant until the L2 returns mem_resp.
- Forwards the granted requester's command/data to the L2 and routes the L2 response back only to that requester.

---
 rtl/l2_arbiter.sv | 123 ++++++++++++
 tb/tb_l2_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter.sv
// Two-way arbiter sharing one L2 port between the L1 I-cache and L1 D-cache.
// Define L2_ARB_ROUND_ROBIN_EN to alternate grants when both requesters are pending.
module l2_arbiter #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned LINE_W = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   input  logic [1:0]        d_byte_enable,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              l2_read,
   output logic              l2_write,
   output logic [ADDR_W-1:0] l2_address,
   output logic [LINE_W-1:0] l2_wdata,
   output logic [1:0]        l2_byte_enable,
   input  logic [LINE_W-1:0] l2_rdata,
   input  logic              l2_resp,
   output logic              busy
);

   typedef enum logic [1:0] {SIdle, SServeI, SServeD} state_e;

   state_e state_q, state_d;
   logic   d_req, i_req, prefer_i;

   assign d_req = d_read | d_write;
   assign i_req = i_read;

`ifdef L2_ARB_ROUND_ROBIN_EN
   logic last_d_q, last_d_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_d_q <= 1'b0;
      end else begin
         last_d_q <= last_d_d;
      end
   end

   // Only consulted when both sides are requesting.
   assign prefer_i = last_d_q;
`else
   assign prefer_i = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
`ifdef L2_ARB_ROUND_ROBIN_EN
      last_d_d = last_d_q;
`endif
      unique case (state_q)
         SIdle: begin
            if (d_req && !(i_req && prefer_i)) begin
               state_d = SServeD;
`ifdef L2_ARB_ROUND_ROBIN_EN
               last_d_d = 1'b1;
`endif
            end else if (i_req) begin
               state_d = SServeI;
`ifdef L2_ARB_ROUND_ROBIN_EN
               last_d_d = 1'b0;
`endif
            end
         end
         SServeI, SServeD: begin
            // Returning through SIdle guarantees a dead cycle before the next command.
            if (l2_resp) begin
               state_d = SIdle;
            end
         end
         default: state_d = SIdle;
      endcase
   end

   always_comb begin
      l2_read        = 1'b0;
      l2_write       = 1'b0;
      l2_address     = '0;
      l2_wdata       = '0;
      l2_byte_enable = 2'b00;
      i_resp         = 1'b0;
      d_resp         = 1'b0;
      unique case (state_q)
         SServeI: begin
            l2_read        = i_read;
            l2_address     = i_address;
            l2_byte_enable = 2'b11;
            i_resp         = l2_resp;
         end
         SServeD: begin
            l2_read        = d_read;
            l2_write       = d_write;
            l2_address     = d_address;
            l2_wdata       = d_wdata;
            l2_byte_enable = d_byte_enable;
            d_resp         = l2_resp;
         end
         default: ;
      endcase
   end

   assign i_rdata = l2_rdata;
   assign d_rdata = l2_rdata;
   assign busy    = (state_q != SIdle);

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level ownership model.
module tb_l2_arbiter;

   localparam int OwnNone = 0;
   localparam int OwnI    = 1;
   localparam int OwnD    = 2;
`ifdef L2_ARB_ROUND_ROBIN_EN
   localparam bit RoundRobin = 1'b1;
`else
   localparam bit RoundRobin = 1'b0;
`endif

   logic         clk, reset;
   logic         i_read, i_resp, d_read, d_write, d_resp;
   logic [15:0]  i_address, d_address, l2_address;
   logic [127:0] i_rdata, d_rdata, d_wdata, l2_wdata, l2_rdata;
   logic [1:0]   d_byte_enable, l2_byte_enable;
   logic         l2_read, l2_write, l2_resp, busy;

   l2_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
      .clk(clk), .reset(reset),
      .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
      .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
      .l2_wdata(l2_wdata), .l2_byte_enable(l2_byte_enable), .l2_rdata(l2_rdata),
      .l2_resp(l2_resp), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          m_own    = OwnNone;
   bit          m_last_d = 1'b0;
   bit          chk_en   = 1'b0;
   bit          busy_prev = 1'b0;
   bit          d_saw, i_saw;
   logic [15:0] glog[$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Who owns the L2 port decides everything the arbiter presents.
   task automatic compare();
      logic         e_rd, e_wr, e_ir, e_dr;
      logic [15:0]  e_a;
      logic [127:0] e_wd;
      logic [1:0]   e_be;
      e_rd = 0; e_wr = 0; e_ir = 0; e_dr = 0; e_a = '0; e_wd = '0; e_be = 2'b00;
      if (m_own == OwnI) begin
         e_rd = i_read; e_a = i_address; e_be = 2'b11; e_ir = l2_resp;
      end else if (m_own == OwnD) begin
         e_rd = d_read; e_wr = d_write; e_a = d_address; e_wd = d_wdata;
         e_be = d_byte_enable; e_dr = l2_resp;
      end
      chk("busy", 128'(busy), 128'(m_own != OwnNone));
      chk("l2_read", 128'(l2_read), 128'(e_rd));
      chk("l2_write", 128'(l2_write), 128'(e_wr));
      chk("l2_address", 128'(l2_address), 128'(e_a));
      chk("l2_wdata", l2_wdata, e_wd);
      chk("l2_byte_enable", 128'(l2_byte_enable), 128'(e_be));
      chk("i_resp", 128'(i_resp), 128'(e_ir));
      chk("d_resp", 128'(d_resp), 128'(e_dr));
      chk("i_rdata", i_rdata, l2_rdata);
      chk("d_rdata", d_rdata, l2_rdata);
   endtask

   task automatic update_model();
      bit dq, iq;
      dq = d_read | d_write;
      iq = i_read;
      if (reset) begin
         m_own = OwnNone; m_last_d = 1'b0;
      end else if (m_own == OwnNone) begin
         if (dq && iq) m_own = (RoundRobin && m_last_d) ? OwnI : OwnD;
         else if (dq)  m_own = OwnD;
         else if (iq)  m_own = OwnI;
         if (m_own == OwnD) m_last_d = 1'b1;
         if (m_own == OwnI) m_last_d = 1'b0;
      end else if (l2_resp) begin
         m_own = OwnNone;
      end
   endtask

   // Advance one cycle: check at negedge, step the model at posedge, return 1 after.
   task automatic tick();
      @(negedge clk);
      if (chk_en) compare();
      d_saw = d_resp;
      i_saw = i_resp;
      if (busy && !busy_prev) glog.push_back(l2_address);
      busy_prev = busy;
      @(posedge clk);
      update_model();
      #1;
   endtask

   task automatic serve_one(input int lat, input bit drop);
      repeat (lat) tick();
      l2_resp = 1'b1;
      #1;
      if (drop && d_resp) begin d_read = 0; d_write = 0; end
      if (drop && i_resp) i_read = 0;
      tick();
      l2_resp = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   logic [15:0] exp5[4];
   bit          d_pend, i_pend;
   int          cnt, lat, r;

   initial begin
      reset = 1; i_read = 1; d_read = 1; d_write = 0;
      i_address = 16'h0def; d_address = 16'h0abc; d_wdata = '0; d_byte_enable = 2'b00;
      l2_rdata = '0; l2_resp = 0;

      // Reset held with both requesting.
      tick();
      chk_en = 1'b1;
      tick();
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_l2_read", 128'(l2_read), 128'(0));
      reset = 0;
      tick();
      chk("post_rst_grant_d", 128'(l2_address), 128'(16'h0abc));
      chk("post_rst_l2_read", 128'(l2_read), 128'(1));
      serve_one(0, 1'b1);
      i_read = 0;
      chk("post_rst_idle", 128'(busy), 128'(0));
      do_reset();

      // I-cache read with 5-cycle L2 latency.
      i_read = 1; i_address = 16'h1230;
      tick();
      chk("i_addr", 128'(l2_address), 128'(16'h1230));
      chk("i_be", 128'(l2_byte_enable), 128'(2'b11));
      repeat (4) tick();
      l2_rdata = {16{8'hA5}};
      l2_resp  = 1;
      #1;
      chk("i_resp_hi", 128'(i_resp), 128'(1));
      chk("i_rdata_a5", i_rdata, {16{8'hA5}});
      chk("i_no_d_resp", 128'(d_resp), 128'(0));
      i_read = 0;
      tick();
      l2_resp = 0;
      chk("i_resp_lo", 128'(i_resp), 128'(0));
      chk("i_read_lo", 128'(l2_read), 128'(0));

      // D-cache write.
      d_write = 1; d_address = 16'h8040; d_byte_enable = 2'b01; d_wdata = 128'h1;
      tick();
      chk("d_wr", 128'(l2_write), 128'(1));
      chk("d_wr_addr", 128'(l2_address), 128'(16'h8040));
      chk("d_wr_data", l2_wdata, 128'h1);
      chk("d_wr_be", 128'(l2_byte_enable), 128'(2'b01));
      tick();
      l2_resp = 1;
      #1;
      chk("d_resp_hi", 128'(d_resp), 128'(1));
      d_write = 0;
      tick();
      l2_resp = 0;
      chk("d_back_idle", 128'(busy), 128'(0));

      // Simultaneous requests from a fresh last_d.
      do_reset();
      glog.delete();
      d_read = 1; d_address = 16'h0100; i_read = 1; i_address = 16'h0200;
      tick();
      chk("both_first_d", 128'(l2_address), 128'(16'h0100));
      serve_one(1, 1'b1);
      chk("bubble_busy", 128'(busy), 128'(0));
      chk("bubble_read", 128'(l2_read), 128'(0));
      tick();
      chk("both_second_i", 128'(l2_address), 128'(16'h0200));
      serve_one(1, 1'b1);
      tick();
      chk("both_count", 128'(glog.size()), 128'(2));

      // Both held continuously for four transactions.
      do_reset();
      glog.delete();
      d_read = 1; d_address = 16'h0300; i_read = 1; i_address = 16'h0400;
      tick();
      for (int k = 0; k < 4; k++) begin
         if (k > 0) tick();
         serve_one(2, 1'b0);
      end
      d_read = 0; i_read = 0;
      tick();
      exp5[0] = 16'h0300;
      exp5[1] = RoundRobin ? 16'h0400 : 16'h0300;
      exp5[2] = 16'h0300;
      exp5[3] = RoundRobin ? 16'h0400 : 16'h0300;
      chk("held_count", 128'(glog.size()), 128'(4));
      for (int k = 0; k < 4 && k < glog.size(); k++) chk("held_order", 128'(glog[k]), 128'(exp5[k]));

      // Reset mid-transaction, then a stray response.
      i_read = 1; i_address = 16'h5555;
      tick();
      tick();
      tick();
      reset = 1;
      tick();
      reset = 0; i_read = 0;
      chk("midrst_idle", 128'(busy), 128'(0));
      l2_resp = 1;
      #1;
      chk("stray_i_resp", 128'(i_resp), 128'(0));
      chk("stray_d_resp", 128'(d_resp), 128'(0));
      tick();
      l2_resp = 0;
      chk("stray_idle", 128'(busy), 128'(0));

      // Randomized traffic: requesters hold until their response, random L2 latency.
      d_pend = 0; i_pend = 0; cnt = 0; lat = 2; d_saw = 0; i_saw = 0;
      for (int c = 0; c < 4000; c++) begin
         if (d_pend && d_saw) begin d_pend = 0; d_read = 0; d_write = 0; end
         if (i_pend && i_saw) begin i_pend = 0; i_read = 0; end
         if (!d_pend && ($urandom % 3 == 0)) begin
            d_pend = 1;
            r = $urandom % 8;
            d_write = (r < 3) || (r == 7);
            d_read  = !d_write || (r == 7);
            d_address = 16'($urandom);
            d_wdata = {$urandom, $urandom, $urandom, $urandom};
            d_byte_enable = 2'($urandom);
         end
         if (!i_pend && ($urandom % 3 == 0)) begin
            i_pend = 1; i_read = 1; i_address = 16'($urandom);
         end
         reset = ($urandom % 250 == 0);
         if (l2_resp || reset) begin
            l2_resp = 0; cnt = 0;
         end else if (busy && (l2_read || l2_write)) begin
            if (cnt >= lat) begin
               l2_resp = 1; l2_rdata = {$urandom, $urandom, $urandom, $urandom};
               lat = $urandom_range(0, 5); cnt = 0;
            end else begin
               cnt++;
            end
         end else if (!busy) begin
            l2_resp = ($urandom % 8 == 0);
         end
         tick();
      end
      reset = 0; l2_resp = 0; d_read = 0; d_write = 0; i_read = 0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
